// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between fetch and data stages.
// Optional fetch starvation guard enabled by defining MEMARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int TIMEOUT      = 255,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    output logic          stall_f,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    input  logic [2:0]    dm_funct3,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_valid,
    output logic          stall_m,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [2:0]    mem_funct3,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          bus_err,
    output logic [1:0]    fsm_state
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_IF = 2'd1;
    localparam logic [1:0] BUSY_DM = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    if ((TIMEOUT < 1) || (TIMEOUT > 65535) || (STARVE_LIMIT < 1)) begin : g_bad_param
        $error("mem_port_arbiter: TIMEOUT must be 1..65535 and STARVE_LIMIT >= 1");
    end

    logic [1:0]  state;
    logic [15:0] tmo_cnt;
    logic        tmo_hit;
    logic        pick_dm;

    assign tmo_hit   = (tmo_cnt == 16'(TIMEOUT - 1));
    assign fsm_state = state;

    // Handshake: a requester holds req (and its fields) until its one-cycle
    // valid pulse; mem_req stays high with mem_* stable until mem_ack or timeout.
    assign stall_f = if_req & ~if_valid;
    assign stall_m = dm_req & ~dm_valid;

`ifdef MEMARB_STARVE_GUARD_EN
    logic [15:0] starve_cnt;

    // Fetch overtakes data once it has waited through STARVE_LIMIT data grants.
    always_comb begin
        pick_dm = dm_req && !(if_req && (starve_cnt == 16'(STARVE_LIMIT)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= 16'd0;
        end else if ((state == IDLE) && (dm_req || if_req)) begin
            if (!pick_dm) begin
                starve_cnt <= 16'd0;
            end else if (if_req) begin
                starve_cnt <= starve_cnt + 16'd1;
            end
        end
    end
`else
    always_comb begin
        pick_dm = dm_req;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tmo_cnt    <= 16'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_funct3 <= 3'b000;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_valid   <= 1'b0;
            dm_valid   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (dm_req || if_req) begin
                        mem_req <= 1'b1;
                        tmo_cnt <= 16'd0;
                        if (pick_dm) begin
                            state      <= BUSY_DM;
                            mem_we     <= dm_we;
                            mem_addr   <= dm_addr;
                            mem_wdata  <= dm_wdata;
                            mem_funct3 <= dm_funct3;
                        end else begin
                            // Instruction fetch is always a full-word read.
                            state      <= BUSY_IF;
                            mem_we     <= 1'b0;
                            mem_addr   <= if_addr;
                            mem_wdata  <= '0;
                            mem_funct3 <= 3'b010;
                        end
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (mem_ack || tmo_hit) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        bus_err <= !mem_ack;
                        if (state == BUSY_DM) begin
                            dm_valid <= 1'b1;
                            dm_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
                        end else begin
                            if_valid <= 1'b1;
                            if_rdata <= mem_ack ? mem_rdata : '0;
                        end
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    tmo_cnt <= 16'd0;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
